// File: rtl/video_sprite_renderer_if.sv
// Bundle of sync-generator inputs, sprite ROM port and RGB/sync outputs of the sprite renderer.
// master = upstream sync generator/ROM/display side, slave = renderer.
interface video_sprite_renderer_if;
   logic        i_hsync;
   logic        i_vsync;
   logic        i_visible;
   logic [9:0]  i_hpos;
   logic [9:0]  i_vpos;
   logic        i_enable;
   logic [3:0]  o_rom_addr;
   logic [15:0] i_rom_data;
   logic [2:0]  o_red;
   logic [2:0]  o_grn;
   logic [2:0]  o_blu;
   logic        o_hsync;
   logic        o_vsync;
   logic [9:0]  o_sprite_x;
   logic [9:0]  o_sprite_y;

   modport master (
      output i_hsync, i_vsync, i_visible, i_hpos, i_vpos, i_enable, i_rom_data,
      input  o_rom_addr, o_red, o_grn, o_blu, o_hsync, o_vsync, o_sprite_x, o_sprite_y
   );

   modport slave (
      input  i_hsync, i_vsync, i_visible, i_hpos, i_vpos, i_enable, i_rom_data,
      output o_rom_addr, o_red, o_grn, o_blu, o_hsync, o_vsync, o_sprite_x, o_sprite_y
   );
endinterface

// File: rtl/video_sprite_renderer.sv
// Draws one bouncing 16x16 1-bpp sprite over a solid background; moves once per frame at vblank start.
// Latency: 2 cycles from sync-generator inputs to RGB/sync; free-running, no backpressure.
module video_sprite_renderer #(
   parameter int         H_VISIBLE   = 640,
   parameter int         V_VISIBLE   = 480,
   parameter int         SPRITE_SIZE = 16,
   parameter int         X_INIT      = 0,
   parameter int         Y_INIT      = 0,
   parameter int         SPEED       = 1,
   parameter logic [8:0] FG_COLOR    = 9'h1FF,
   parameter logic [8:0] BG_COLOR    = 9'h000
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   video_sprite_renderer_if.slave  bus
);

   localparam logic [10:0] X_MAX  = 11'(H_VISIBLE - SPRITE_SIZE);
   localparam logic [10:0] Y_MAX  = 11'(V_VISIBLE - SPRITE_SIZE);
   localparam logic [10:0] STEP11 = 11'(SPEED);
   localparam logic [9:0]  STEP10 = 10'(SPEED);
   localparam logic [10:0] SIZE11 = 11'(SPRITE_SIZE);
   localparam logic [9:0]  V_TICK = 10'(V_VISIBLE);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVE_X = 2'd1,
      MOVE_Y = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [9:0]  r_x;
   logic [9:0]  r_y;
   logic        r_dx_neg;
   logic        r_dy_neg;
   logic [9:0]  w_x_nxt;
   logic [9:0]  w_y_nxt;
   logic        w_dx_neg_nxt;
   logic        w_dy_neg_nxt;

   // Pipeline stage registers
   logic        r_vis0;
   logic        r_hs0;
   logic        r_vs0;
   logic        r_hit0;
   logic [3:0]  r_col0;
   logic [3:0]  r_rom_addr;
   logic [8:0]  r_rgb;
   logic        r_hs1;
   logic        r_vs1;

   logic        w_tick;
   logic [10:0] w_x_sum;
   logic [10:0] w_y_sum;
   logic [10:0] w_x_end;
   logic [10:0] w_y_end;
   logic        w_in_x;
   logic        w_in_y;
   logic        w_pix;

   assign w_tick  = (bus.i_hpos == 10'd0) && (bus.i_vpos == V_TICK);
   assign w_x_sum = {1'b0, r_x} + STEP11;
   assign w_y_sum = {1'b0, r_y} + STEP11;
   // 11-bit end bounds so a sprite near column/line 1023 cannot wrap
   assign w_x_end = {1'b0, r_x} + SIZE11;
   assign w_y_end = {1'b0, r_y} + SIZE11;
   assign w_in_x  = ({1'b0, bus.i_hpos} >= {1'b0, r_x}) && ({1'b0, bus.i_hpos} < w_x_end);
   assign w_in_y  = ({1'b0, bus.i_vpos} >= {1'b0, r_y}) && ({1'b0, bus.i_vpos} < w_y_end);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_x      <= 10'(X_INIT);
         r_y      <= 10'(Y_INIT);
         r_dx_neg <= 1'b0;
         r_dy_neg <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_dx_neg <= w_dx_neg_nxt;
         r_dy_neg <= w_dy_neg_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_x_nxt      = r_x;
      w_y_nxt      = r_y;
      w_dx_neg_nxt = r_dx_neg;
      w_dy_neg_nxt = r_dy_neg;
      case (r_state)
         IDLE: begin
            if (w_tick && bus.i_enable) begin
               w_state_nxt = MOVE_X;
            end
         end
         MOVE_X: begin
            w_state_nxt = MOVE_Y;
            if (!r_dx_neg) begin
               if (w_x_sum > X_MAX) begin
                  w_x_nxt      = X_MAX[9:0];
                  w_dx_neg_nxt = 1'b1;
               end else begin
                  w_x_nxt = w_x_sum[9:0];
               end
            end else begin
               if ({1'b0, r_x} < STEP11) begin
                  w_x_nxt      = 10'd0;
                  w_dx_neg_nxt = 1'b0;
               end else begin
                  w_x_nxt = r_x - STEP10;
               end
            end
         end
         MOVE_Y: begin
            w_state_nxt = IDLE;
            if (!r_dy_neg) begin
               if (w_y_sum > Y_MAX) begin
                  w_y_nxt      = Y_MAX[9:0];
                  w_dy_neg_nxt = 1'b1;
               end else begin
                  w_y_nxt = w_y_sum[9:0];
               end
            end else begin
               if ({1'b0, r_y} < STEP11) begin
                  w_y_nxt      = 10'd0;
                  w_dy_neg_nxt = 1'b0;
               end else begin
                  w_y_nxt = r_y - STEP10;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // r_rom_addr acts as the ROM's address register, so its data is back in S1
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vis0     <= 1'b0;
         r_hs0      <= 1'b0;
         r_vs0      <= 1'b0;
         r_hit0     <= 1'b0;
         r_col0     <= 4'd0;
         r_rom_addr <= 4'd0;
      end else begin
         r_vis0     <= bus.i_visible;
         r_hs0      <= bus.i_hsync;
         r_vs0      <= bus.i_vsync;
         r_hit0     <= w_in_x && w_in_y;
         r_col0     <= bus.i_hpos[3:0] - r_x[3:0];
         r_rom_addr <= bus.i_vpos[3:0] - r_y[3:0];
      end
   end

   assign w_pix = bus.i_rom_data[4'd15 - r_col0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rgb <= 9'd0;
         r_hs1 <= 1'b0;
         r_vs1 <= 1'b0;
      end else begin
         r_hs1 <= r_hs0;
         r_vs1 <= r_vs0;
         if (!r_vis0) begin
            r_rgb <= 9'd0;
         end else if (r_hit0 && w_pix) begin
            r_rgb <= FG_COLOR;
         end else begin
            r_rgb <= BG_COLOR;
         end
      end
   end

   assign bus.o_rom_addr = r_rom_addr;
   assign bus.o_red      = r_rgb[8:6];
   assign bus.o_grn      = r_rgb[5:3];
   assign bus.o_blu      = r_rgb[2:0];
   assign bus.o_hsync    = r_hs1;
   assign bus.o_vsync    = r_vs1;
   assign bus.o_sprite_x = r_x;
   assign bus.o_sprite_y = r_y;

endmodule

// File: tb/tb_video_sprite_renderer.sv
// Scoreboard bench for video_sprite_renderer: three instances with different parameters share one input stream.
module tb_video_sprite_renderer;

   localparam logic [8:0] FG_A = 9'h1FF;
   localparam logic [8:0] BG_A = 9'h000;
   localparam logic [8:0] FG_C = 9'h1C0;
   localparam logic [8:0] BG_C = 9'h049;

   logic       clk;
   logic       rst;
   logic [9:0] hpos;
   logic [9:0] vpos;
   logic       vis;
   logic       hs;
   logic       vs;
   logic       en;
   int         cyc;
   int         total;
   int         bad;

   logic [15:0] rom_a [16];
   logic [15:0] rom_c [16];

   video_sprite_renderer_if ifa();
   video_sprite_renderer_if ifb();
   video_sprite_renderer_if ifc();

   assign ifa.i_hpos = hpos;  assign ifb.i_hpos = hpos;  assign ifc.i_hpos = hpos;
   assign ifa.i_vpos = vpos;  assign ifb.i_vpos = vpos;  assign ifc.i_vpos = vpos;
   assign ifa.i_visible = vis; assign ifb.i_visible = vis; assign ifc.i_visible = vis;
   assign ifa.i_hsync = hs;   assign ifb.i_hsync = hs;   assign ifc.i_hsync = hs;
   assign ifa.i_vsync = vs;   assign ifb.i_vsync = vs;   assign ifc.i_vsync = vs;
   assign ifa.i_enable = en;  assign ifb.i_enable = en;  assign ifc.i_enable = en;
   assign ifa.i_rom_data = rom_a[ifa.o_rom_addr];
   assign ifb.i_rom_data = rom_a[ifb.o_rom_addr];
   assign ifc.i_rom_data = rom_c[ifc.o_rom_addr];

   video_sprite_renderer #(.X_INIT(100), .Y_INIT(50), .SPEED(1),
                           .FG_COLOR(FG_A), .BG_COLOR(BG_A))
      u_a (.i_clk(clk), .i_rst(rst), .bus(ifa));

   video_sprite_renderer #(.X_INIT(622), .Y_INIT(0), .SPEED(4))
      u_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

   video_sprite_renderer #(.H_VISIBLE(34), .X_INIT(14), .Y_INIT(464), .SPEED(4),
                           .FG_COLOR(FG_C), .BG_COLOR(BG_C))
      u_c (.i_clk(clk), .i_rst(rst), .bus(ifc));

   typedef struct {
      int         due;
      int         inst;
      logic [8:0] rgb;
      logic       hs;
      logic       vs;
   } exp_t;

   typedef struct {
      int         due;
      logic [3:0] addr;
   } aexp_t;

   exp_t  q[$];
   aexp_t qa[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [8:0] rgb_of(int inst);
      if (inst == 0) return {ifa.o_red, ifa.o_grn, ifa.o_blu};
      return {ifc.o_red, ifc.o_grn, ifc.o_blu};
   endfunction

   function automatic logic [1:0] sync_of(int inst);
      if (inst == 0) return {ifa.o_hsync, ifa.o_vsync};
      return {ifc.o_hsync, ifc.o_vsync};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops scoreboard entries as the DUT presents each output cycle
   initial begin
      exp_t  e;
      aexp_t a;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            total = total + 1;
            if (e.due != cyc || rgb_of(e.inst) !== e.rgb || sync_of(e.inst) !== {e.hs, e.vs}) begin
               bad = bad + 1;
               $display("FAIL pix inst=%0d due=%0d now=%0d: rgb=%h hs/vs=%b, expected rgb=%h hs/vs=%b%b",
                        e.inst, e.due, cyc, rgb_of(e.inst), sync_of(e.inst), e.rgb, e.hs, e.vs);
            end
         end
         while (qa.size() > 0 && qa[0].due <= cyc) begin
            a = qa.pop_front();
            total = total + 1;
            if (a.due != cyc || ifc.o_rom_addr !== a.addr) begin
               bad = bad + 1;
               $display("FAIL rom_addr due=%0d now=%0d: got %0d expected %0d",
                        a.due, cyc, ifc.o_rom_addr, a.addr);
            end
         end
      end
   end

   // Drive one pixel cycle; called and returns at #1 after a rising edge
   task automatic px(input int h, input int v, input bit vi, input bit hsv, input bit vsv,
                     input int inst, input logic [8:0] ergb, input bit ca, input logic [3:0] ea);
      exp_t  e;
      aexp_t a;
      hpos = 10'(h);
      vpos = 10'(v);
      vis  = vi;
      hs   = hsv;
      vs   = vsv;
      e.due = cyc + 2; e.inst = inst; e.rgb = ergb; e.hs = hsv; e.vs = vsv;
      q.push_back(e);
      if (ca) begin
         a.due = cyc + 1; a.addr = ea;
         qa.push_back(a);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      hpos = 10'd700; vpos = 10'd500; vis = 1'b0; hs = 1'b0; vs = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Vblank-start tick; checks sprite A moves only in the cycles right after it
   task automatic tick(input bit drop_en, input int ax0, input int ay0, input int ax1, input int ay1);
      hpos = 10'd0; vpos = 10'd480; vis = 1'b0; hs = 1'b0; vs = 1'b0;
      @(posedge clk); #1;
      hpos = 10'd1;
      if (drop_en) en = 1'b0;
      chk("a_x_hold", int'(ifa.o_sprite_x), ax0);
      @(posedge clk); #1;
      chk("a_y_hold", int'(ifa.o_sprite_y), ay0);
      @(posedge clk); #1;
      chk("a_x_new", int'(ifa.o_sprite_x), ax1);
      chk("a_y_new", int'(ifa.o_sprite_y), ay1);
      @(posedge clk); #1;
   endtask

   int bx_tbl [2] = '{624, 620};
   int cx_tbl [8] = '{18, 18, 14, 10, 6, 2, 0, 4};

   initial begin
      total = 0;
      bad   = 0;
      for (int r = 0; r < 16; r++) begin
         rom_a[r] = 16'h8001;
         rom_c[r] = (r == 0 || (r % 2) == 1) ? 16'h8000 : 16'h0000;
      end
      rst = 1'b1; en = 1'b0;
      hpos = 10'd100; vpos = 10'd50; vis = 1'b1; hs = 1'b1; vs = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rgb", int'(rgb_of(0)), 0);
      chk("rst_sync", int'(sync_of(0)), 0);
      chk("rst_rom_addr", int'(ifa.o_rom_addr), 0);
      chk("rst_a_x", int'(ifa.o_sprite_x), 100);
      chk("rst_a_y", int'(ifa.o_sprite_y), 50);
      chk("rst_b_x", int'(ifb.o_sprite_x), 622);
      chk("rst_c_y", int'(ifc.o_sprite_y), 464);

      rst = 1'b0;
      px(100, 50, 1, 0, 0, 0, 9'h1FF, 0, 4'd0);
      px(101, 50, 1, 0, 0, 0, 9'h000, 0, 4'd0);
      px(115, 50, 1, 0, 0, 0, 9'h1FF, 0, 4'd0);
      px(116, 50, 1, 0, 0, 0, 9'h000, 0, 4'd0);
      px( 99, 50, 1, 0, 0, 0, 9'h000, 0, 4'd0);
      px(100, 65, 1, 0, 0, 0, 9'h1FF, 0, 4'd0);
      px(100, 66, 1, 0, 0, 0, 9'h000, 0, 4'd0);
      px(100, 49, 1, 0, 0, 0, 9'h000, 0, 4'd0);
      px(100, 50, 0, 0, 0, 0, 9'h000, 0, 4'd0);
      px(700, 50, 0, 1, 0, 0, 9'h000, 0, 4'd0);
      px(700, 50, 0, 1, 0, 0, 9'h000, 0, 4'd0);
      px(700, 50, 0, 1, 0, 0, 9'h000, 0, 4'd0);
      px(700, 50, 0, 0, 0, 0, 9'h000, 0, 4'd0);
      px(700, 50, 0, 0, 1, 0, 9'h000, 0, 4'd0);
      px(700, 50, 0, 0, 1, 0, 9'h000, 0, 4'd0);
      px(700, 50, 0, 0, 0, 0, 9'h000, 0, 4'd0);

      // Bottom-edge sprite in instance C: rows 0..15 on lines 464..479, none on 480
      for (int r = 0; r < 16; r++) begin
         px(14, 464 + r, 1, 0, 0, 1, (r == 0 || (r % 2) == 1) ? FG_C : BG_C, 1, 4'(r));
      end
      px(14, 480, 1, 0, 0, 1, BG_C, 1, 4'd0);
      px(29, 470, 1, 0, 0, 1, BG_C, 0, 4'd0);
      px(13, 465, 1, 0, 0, 1, BG_C, 0, 4'd0);
      idle(3);

      en = 1'b1;
      for (int f = 1; f <= 8; f++) begin
         tick(0, 99 + f, 49 + f, 100 + f, 50 + f);
         if (f <= 2) chk("b_x", int'(ifb.o_sprite_x), bx_tbl[f - 1]);
         chk("c_x", int'(ifc.o_sprite_x), cx_tbl[f - 1]);
      end

      en = 1'b0;
      for (int f = 0; f < 5; f++) begin
         tick(0, 108, 58, 108, 58);
      end

      en = 1'b1;
      tick(1, 108, 58, 109, 59);
      tick(0, 109, 59, 109, 59);

      // Reset in the middle of a visible line while the sprite is being drawn
      hpos = 10'd109; vpos = 10'd59; vis = 1'b1; hs = 1'b1; vs = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_rgb", int'(rgb_of(0)), int'(FG_A));
      chk("pre_rst_hs", int'(ifa.o_hsync), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_rgb", int'(rgb_of(0)), 0);
      chk("mid_rst_hs", int'(ifa.o_hsync), 0);
      chk("mid_rst_x", int'(ifa.o_sprite_x), 100);
      chk("mid_rst_y", int'(ifa.o_sprite_y), 50);
      rst = 1'b0;
      px(100, 50, 1, 1, 0, 0, 9'h1FF, 0, 4'd0);
      px(101, 50, 1, 0, 0, 0, 9'h000, 0, 4'd0);
      idle(4);

      chk("queue_drained", q.size() + qa.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
